// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access controller sitting directly in front of the word-wide
// data memory (d_mem). Loads are single cycle with a registered, aligned and
// sign/zero-extended result. Word stores go straight through. Byte and
// halfword stores are performed as a read-modify-write: the word is read in
// IDLE while the pipeline is stalled, then the merged word is written in
// RMW_WR.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned requests (odd halfword, unaligned word, size 11)
//               are dropped and flagged with a one-cycle misalign pulse.
//   undefined : no checking; halfwords select their lane with addr[1] only,
//               words ignore addr[1:0], size 11 behaves as a word access.
//
// Ports
//   clk          rising-edge clock (d_mem samples on the falling edge)
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed   load extension: 1 = sign, 0 = zero
//   req_addr     byte address
//   req_wdata    store data, right-justified
//   stall        requester must hold req_* for one more cycle
//   load_valid   one-cycle pulse, load_data valid
//   load_data    extended load result
//   misalign     one-cycle pulse, request was dropped
//   mem_adr      word address to d_mem (bits [1:0] forced to 0)
//   mem_data_in  write data to d_mem
//   mem_WrEn     write enable to d_mem
//   mem_data_out read data from d_mem
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  load_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misalign,
    output logic [ADDR_WIDTH-1:0] mem_adr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_WrEn,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    state_t                  state_r;
    logic                    load_valid_r;
    logic [DATA_WIDTH-1:0]   load_data_r;
    logic                    misalign_r;
    logic [ADDR_WIDTH-1:0]   rmw_addr_r;
    logic [DATA_WIDTH-1:0]   rmw_data_r;

    logic                    size_word_s;
    logic                    misalign_s;
    logic                    accept_s;
    logic                    load_s;
    logic                    word_store_s;
    logic                    sub_store_s;
    logic [ADDR_WIDTH-1:0]   word_addr_s;

    // Extract the addressed lane of a word and extend it to full width.
    // Halfwords use offs[1] only, so an odd halfword (when unchecked) still
    // maps to a well-defined lane.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            offs,
        input logic [1:0]            size,
        input logic                  sgn
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (offs)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        if (offs[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'b00:   r = {{(DATA_WIDTH-8){sgn & b[7]}}, b};
            2'b01:   r = {{(DATA_WIDTH-16){sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the read word with the low bits of wdata.
    function automatic logic [DATA_WIDTH-1:0] merge_store(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            offs,
        input logic [1:0]            size,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (offs)
                    2'b00:   r[7:0]   = wdata[7:0];
                    2'b01:   r[15:8]  = wdata[7:0];
                    2'b10:   r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (offs[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0]  = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign word_addr_s = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    // Request decode: alignment check and classification of the accepted request.
    always_comb begin
        size_word_s = (req_size == 2'b10) || (req_size == 2'b11);
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_s = ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                  ||  (req_size == 2'b11);
`else
        misalign_s = 1'b0;
`endif
        // In RMW_WR the held request is the one being completed, so nothing new is accepted.
        accept_s     = (state_r == ST_IDLE) && req_valid && !misalign_s;
        load_s       = accept_s && !req_we;
        word_store_s = accept_s && req_we && size_word_s;
        sub_store_s  = accept_s && req_we && !size_word_s;
    end

    // Memory-side drive: reset overrides everything, RMW_WR replays the merged word.
    always_comb begin
        stall       = 1'b0;
        mem_WrEn    = 1'b0;
        mem_adr     = word_addr_s;
        mem_data_in = req_wdata;
        if (rst) begin
            mem_adr     = {ADDR_WIDTH{1'b0}};
        end else if (state_r == ST_RMW_WR) begin
            mem_adr     = rmw_addr_r;
            mem_data_in = rmw_data_r;
            mem_WrEn    = 1'b1;
        end else begin
            stall       = sub_store_s;
            mem_WrEn    = word_store_s;
        end
    end

    // Control FSM plus registered load result and misalign pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            load_valid_r <= 1'b0;
            load_data_r  <= {DATA_WIDTH{1'b0}};
            misalign_r   <= 1'b0;
            rmw_addr_r   <= {ADDR_WIDTH{1'b0}};
            rmw_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            load_valid_r <= load_s;
            misalign_r   <= (state_r == ST_IDLE) && req_valid && misalign_s;
            if (load_s) begin
                load_data_r <= extend_load(mem_data_out, req_addr[1:0], req_size, req_signed);
            end else begin
                load_data_r <= load_data_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (sub_store_s) begin
                        rmw_addr_r <= word_addr_s;
                        rmw_data_r <= merge_store(mem_data_out, req_addr[1:0], req_size, req_wdata);
                        state_r    <= ST_RMW_WR;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_RMW_WR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_valid = load_valid_r;
    assign load_data  = load_data_r;
    assign misalign   = misalign_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A behavioural d_mem (combinational
// read, falling-edge write) is attached to the memory port. A separate
// reference memory is updated by the bench as stimulus is issued; expected
// load results are pushed into a scoreboard queue and popped by a monitor when
// the result is due. Honours MEM_MISALIGN_CHECK_EN like the design.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign;
    logic [31:0] mem_adr;
    logic [31:0] mem_data_in;
    logic        mem_WrEn;
    logic [31:0] mem_data_out;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] dmem    [0:63];
    logic [31:0] exp_mem [0:63];
    logic        mem_clear = 1'b1;
    logic        mon_en    = 1'b0;
    int          cyc       = 0;
    int          mis_due   = -1;
    int          n_checks  = 0;
    int          n_fail    = 0;

    mem_access_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misalign     (misalign),
        .mem_adr      (mem_adr),
        .mem_data_in  (mem_data_in),
        .mem_WrEn     (mem_WrEn),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected results.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural d_mem: combinational read, write on the falling edge.
    assign mem_data_out = dmem[mem_adr[7:2]];
    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
        end else if (mem_WrEn) begin
            dmem[mem_adr[7:2]] <= mem_data_in;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference load extraction (shift/mask formulation).
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (word >> (8 * a[1:0])) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (word >> (16 * a[1])) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Reference sub-word merge (mask formulation).
    function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] a,
                                              input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (size == 2'b00) begin
            sh = 8 * a[1:0];
            mask = 32'h0000_00FF << sh;
        end else begin
            sh = 16 * a[1];
            mask = 32'h0000_FFFF << sh;
        end
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    // Scoreboard monitor: compares load_valid/load_data/misalign mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check_eq("load_valid", load_valid, 32'd1);
                check_eq("load_data", load_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check_eq("load_valid_idle", load_valid, 32'd0);
            end
            check_eq("misalign", misalign, (cyc == mis_due) ? 32'd1 : 32'd0);
        end
    end

    task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_eq("idle_stall", stall, 32'd0);
            check_eq("idle_wren", mem_WrEn, 32'd0);
        end
    endtask

    task automatic word_store(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, 2'b10, 1'b0, a, d);
        #1;
        check_eq("ws_stall", stall, 32'd0);
        check_eq("ws_wren", mem_WrEn, 32'd1);
        check_eq("ws_adr", mem_adr, a & 32'hFFFF_FFFC);
        check_eq("ws_data", mem_data_in, d);
        exp_mem[a[7:2]] = d;
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        exp_t e;
        drive(1'b1, 1'b0, sz, sg, a, 32'h0);
        #1;
        check_eq("ld_stall", stall, 32'd0);
        check_eq("ld_wren", mem_WrEn, 32'd0);
        e.due  = cyc + 1;
        e.data = ref_load(exp_mem[a[7:2]], a, sz, sg);
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic sub_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] merged;
        merged = ref_merge(exp_mem[a[7:2]], a, sz, d);
        drive(1'b1, 1'b1, sz, 1'b0, a, d);
        #1;
        check_eq("rmw_rd_stall", stall, 32'd1);
        check_eq("rmw_rd_wren", mem_WrEn, 32'd0);
        @(posedge clk); #1;
        check_eq("rmw_wr_stall", stall, 32'd0);
        check_eq("rmw_wr_wren", mem_WrEn, 32'd1);
        check_eq("rmw_wr_adr", mem_adr, a & 32'hFFFF_FFFC);
        check_eq("rmw_wr_data", mem_data_in, merged);
        exp_mem[a[7:2]] = merged;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;

        // Reset with a sub-word store pending: reset must override everything.
        rst = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0045, 32'h0000_00AA);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wren", mem_WrEn, 32'd0);
        check_eq("rst_adr", mem_adr, 32'h0);
        check_eq("rst_stall", stall, 32'd0);
        check_eq("rst_load_valid", load_valid, 32'd0);
        check_eq("rst_load_data", load_data, 32'h0);
        check_eq("rst_misalign", misalign, 32'd0);
        rst = 1'b0;
        mem_clear = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // Word store then word load, no stall.
        word_store(32'h10, 32'hDEAD_BEEF);
        load(32'h10, 2'b10, 1'b0);

        // Byte loads from top lane, signed and unsigned.
        word_store(32'h20, 32'h1122_3344);
        load(32'h23, 2'b00, 1'b1);
        load(32'h23, 2'b00, 1'b0);

        // Negative halfword and byte sign extension.
        word_store(32'h20, 32'h80FF_0000);
        load(32'h22, 2'b01, 1'b1);
        load(32'h22, 2'b01, 1'b0);
        load(32'h23, 2'b00, 1'b1);
        load(32'h21, 2'b00, 1'b1);

        // Byte read-modify-write then read back.
        word_store(32'h20, 32'h1122_3344);
        idle(1);
        sub_store(32'h21, 2'b00, 32'hFFFF_FFAB);
        load(32'h20, 2'b10, 1'b0);
        sub_store(32'h20, 2'b01, 32'h0000_A5C3);
        load(32'h20, 2'b10, 1'b0);

        // Odd halfword store and unaligned word load.
        word_store(32'h30, 32'hCAFE_F00D);
        idle(1);
`ifdef MEM_MISALIGN_CHECK_EN
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000_5555);
        #1;
        check_eq("mis_stall", stall, 32'd0);
        check_eq("mis_wren", mem_WrEn, 32'd0);
        mis_due = cyc + 1;
        @(posedge clk); #1;
        idle(1);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h32, 32'h0);
        #1;
        mis_due = cyc + 1;
        @(posedge clk); #1;
        idle(1);
        drive(1'b1, 1'b1, 2'b11, 1'b0, 32'h30, 32'h1234_5678);
        #1;
        check_eq("mis11_wren", mem_WrEn, 32'd0);
        mis_due = cyc + 1;
        @(posedge clk); #1;
        idle(1);
`else
        sub_store(32'h31, 2'b01, 32'h0000_5555);
        load(32'h32, 2'b10, 1'b0);
`endif
        load(32'h30, 2'b10, 1'b0);

        // Reset asserted during the write cycle of a halfword RMW.
        word_store(32'h40, 32'h0102_0304);
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF);
        #1;
        check_eq("rstrmw_rd_stall", stall, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("rstrmw_wren", mem_WrEn, 32'd0);
        check_eq("rstrmw_adr", mem_adr, 32'h0);
        check_eq("rstrmw_stall", stall, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("post_rst_load_valid", load_valid, 32'd0);
        check_eq("post_rst_load_data", load_data, 32'h0);
        check_eq("post_rst_misalign", misalign, 32'd0);
        check_eq("post_rst_stall", stall, 32'd0);
        @(posedge clk); #1;
        load(32'h40, 2'b10, 1'b0);
        sub_store(32'h43, 2'b00, 32'h0000_0077);
        load(32'h40, 2'b10, 1'b0);

        // Alternating word store / word load, one per cycle.
        for (int i = 0; i < 8; i++) begin
            a = 32'h50 + 32'(4 * (i / 2));
            if (i % 2 == 0) begin
                d = $urandom;
                word_store(a, d);
            end else begin
                load(a, 2'b10, 1'b0);
            end
        end
        idle(3);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 64; i++) begin
            check_eq("mem_contents", dmem[i], exp_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller directly upstream of the data memory wrapper (`d_mem`), which is word-wide. Accepts load/store requests from the pipeline's MEM stage, drives the data memory's word address, write data and write enable, and returns aligned, sign- or zero-extended load data. Byte and halfword stores use a two-cycle read-modify-write sequence, and the pipeline is stalled for the read cycle.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of requests and of `mem_adr`
- `DATA_WIDTH`, 32, word width; only 32 is supported
- `clk`  in  1  clock, rising edge; data memory samples on the falling edge of the same clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_wdata`  in  DATA_WIDTH  store data, right-justified
- `stall`  out  1  requester must hold all `req_*` inputs unchanged next cycle
- `load_valid`  out  1  one-cycle pulse; `load_data` is valid
- `load_data`  out  DATA_WIDTH  extended load result
- `misalign`  out  1  one-cycle pulse; request was dropped
- `mem_adr`  out  ADDR_WIDTH  to `d_mem` `adr`; `req_addr` with bits [1:0] forced to 0
- `mem_data_in`  out  DATA_WIDTH  to `d_mem` `data_in`
- `mem_WrEn`  out  1  to `d_mem` `WrEn`
- `mem_data_out`  in  DATA_WIDTH  from `d_mem` `data_out`; valid before the next rising edge after `mem_adr` is driven

## Operation
- Little-endian byte lanes: the byte at `addr[1:0]=k` is `data[8k+7:8k]`. The halfword at `addr[1]=h` is `data[16h+15:16h]`.
- FSM states: IDLE and RMW_WR.
- IDLE, load: `mem_adr` is driven combinationally and `mem_WrEn`=0. The selected lane of `mem_data_out` is extended and registered into `load_data`.
- IDLE, word store: `mem_data_in`=`req_wdata`, `mem_WrEn`=1 combinationally, `stall`=0.
- IDLE, byte/half store: `mem_WrEn`=0 and `stall`=1.
  - The unit reads the word and, at the rising edge, registers the merged word and the address.
  - Merged word = the read word with the target lane replaced by the low bits of `req_wdata`.
  - Next state: RMW_WR.
- RMW_WR: drives the registered address and merged word with `mem_WrEn`=1 and `stall`=0.
  - The held `req_*` inputs are ignored; this is the cycle in which that request is consumed.
  - Next state: IDLE.
- Misaligned requests are dropped: no write and no `load_valid`; `misalign` pulses instead. A request is misaligned when:
  - halfword with `addr[0]`=1,
  - word with `addr[1:0]`≠0, or
  - `req_size`=11.
- No request (`req_valid`=0): `mem_WrEn`=0 and `stall`=0.

## Timing
- Reset values: state IDLE; `load_valid`=0, `load_data`=0, `misalign`=0, `stall`=0.
- While `rst`=1, `mem_WrEn`=0 and `mem_adr`=0, overriding all other conditions.
- Load latency: accepted in cycle N, so `load_valid` and `load_data` appear in N+1 for exactly one cycle.
- Word store: written at the falling edge of cycle N. No stall.
- Byte/half store:
  - cycle N: read, `stall`=1.
  - cycle N+1: write at its falling edge, `stall`=0.
  - The next request can be issued in N+2. Throughput is one sub-word store per 2 cycles.
- `misalign` pulses in N+1 for a request in cycle N.
- Back-to-back loads and word stores: one per cycle, no bubbles.
- A load in N+2 to the address written in N+1 returns the new data.
- Reset asserted in RMW_WR: the write is suppressed that cycle and the state returns to IDLE.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: misalignment detection and dropping are enabled as described above.
- Undefined:
  - No misalignment checking; `misalign` is tied to 0.
  - Halfword accesses use only `addr[1]` for lane selection.
  - Word accesses ignore `addr[1:0]`.
  - `req_size`=11 is treated as a word access.

## Test plan
- Word store 0xDEADBEEF to address 0x10, then word load from 0x10: `stall` never asserted, `load_data`=0xDEADBEEF in the cycle after the load.
- Memory word 0x11223344 at 0x20; signed byte load at 0x23, then unsigned byte load at 0x23: `load_data`=0x00000011 for both. Repeat with the word 0x80FF0000 and a signed halfword load at 0x22: `load_data`=0xFFFF80FF.
- Byte store 0xAB to 0x21 over 0x11223344:
  - `stall`=1 for one cycle, then `mem_WrEn`=1 with `mem_data_in`=0x1122AB44.
  - A following word load of 0x20 returns 0x1122AB44.
- With `MEM_MISALIGN_CHECK_EN` defined, halfword store to 0x31: `misalign`=1 next cycle, `mem_WrEn` stays 0, memory is unchanged.
- Assert `rst` during the RMW_WR cycle of a halfword store to 0x40: no write occurs, all outputs return to reset values, and the next request is accepted normally.
- Alternate word load and word store every cycle for 8 cycles: `stall` stays 0 and every load returns the value most recently stored at its address.
